// File: rtl/cop_ise_pkg.sv
// Shared opcodes, funct7 codes, FSM/op enums and the rotate helper for the Xoodyak ISE coprocessor.
// Pure definitions: no latency, no flow control.
package cop_ise_pkg;

  localparam logic [6:0] CUSTOM_0 = 7'b0001011;
  localparam logic [6:0] CUSTOM_1 = 7'b0101011;
  localparam logic [6:0] CUSTOM_2 = 7'b1011011;
  localparam logic [6:0] CUSTOM_3 = 7'b1111011;

  localparam logic [6:0] FUNCT_XORROL = 7'b0100000;
  localparam logic [6:0] FUNCT_ANDN   = 7'b0100001;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WB
  } state_t;

  typedef enum logic {
    OP_XORROL,
    OP_ANDN
  } op_t;

  // Doubling the word turns a left rotate into a plain shift of the upper half.
  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned amt);
    logic [63:0] dbl;
    dbl = {x, x} << (amt % 32);
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/cop_ise_pipe_if.sv
// Core <-> coprocessor instruction/result bundle; master is the core, slave is the coprocessor.
// Handshake: valid/ready for issue, wr/rdywr for write-back.
interface cop_ise_pipe_if;

  logic        cop_valid;
  logic        cop_rdywr;
  logic        cop_ready;
  logic        cop_wait;
  logic        cop_wr;
  logic [31:0] cop_insn;
  logic [31:0] cop_rs1;
  logic [31:0] cop_rs2;
  logic [31:0] cop_rd;

  modport master (
    output cop_valid, cop_rdywr, cop_insn, cop_rs1, cop_rs2,
    input  cop_ready, cop_wait, cop_wr, cop_rd
  );

  modport slave (
    input  cop_valid, cop_rdywr, cop_insn, cop_rs1, cop_rs2,
    output cop_ready, cop_wait, cop_wr, cop_rd
  );

endinterface

// File: rtl/xoodyak_ise_alu.sv
// Combinational Xoodyak ISE datapath: XORROL (two fixed rotates then XOR) and ANDN.
// Zero latency, no flow control.
module xoodyak_ise_alu
  import cop_ise_pkg::*;
#(
  parameter int unsigned ROT_A = 5,
  parameter int unsigned ROT_B = 14
) (
  input  op_t         op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] res
);

  always_comb begin
    res = '0;
    case (op)
      OP_XORROL: res = rol32(rs1, ROT_A) ^ rol32(rs2, ROT_B);
      OP_ANDN:   res = ~rs1 & rs2;
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/cop_ise_pipe.sv
// Registered CUSTOM_1 coprocessor: decode, capture, LATENCY result stages, then hold in WB until cop_rdywr.
// Result appears LATENCY+1 cycles after acceptance; unsupported ops retire combinationally in IDLE.
module cop_ise_pipe
  import cop_ise_pkg::*;
#(
  parameter logic [1:0]  ISE_V   = 2'b11,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ROT_A   = 5,
  parameter int unsigned ROT_B   = 14
) (
  input logic           cop_clk,
  input logic           cop_rst,
  cop_ise_pipe_if.slave cop
);

  localparam int unsigned     CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stage_q [LATENCY+1];
  logic [31:0]      stage_d [LATENCY+1];

  logic        hit_xorrol;
  logic        hit_andn;
  logic        sel;
  logic        capture;
  logic        shift;
  op_t         op;
  logic [31:0] alu_res;
  logic        ready;
  logic        busy;
  logic        wr;
  logic [31:0] rd;
  logic        unused_insn;

  // Only opcode and funct7 take part in decode; register fields are the core's business.
  assign unused_insn = ^cop.cop_insn[24:7];

  always_comb begin
    hit_xorrol = ISE_V[1] && (cop.cop_insn[31:25] == FUNCT_XORROL);
    hit_andn   = ISE_V[0] && (cop.cop_insn[31:25] == FUNCT_ANDN);
    sel        = cop.cop_valid && (state_q == IDLE) &&
                 (cop.cop_insn[6:0] == CUSTOM_1) && (hit_xorrol || hit_andn);
    op         = hit_xorrol ? OP_XORROL : OP_ANDN;
  end

  xoodyak_ise_alu #(
    .ROT_A (ROT_A),
    .ROT_B (ROT_B)
  ) u_alu (
    .op  (op),
    .rs1 (cop.cop_rs1),
    .rs2 (cop.cop_rs2),
    .res (alu_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    shift   = 1'b0;
    ready   = 1'b0;
    busy    = 1'b0;
    wr      = 1'b0;
    rd      = '0;
    case (state_q)
      IDLE: begin
        if (sel) begin
          capture = 1'b1;
          busy    = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 0) ? BUSY : WB;
        end else if (cop.cop_valid) begin
          ready = 1'b1;
        end
      end
      BUSY: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        wr = 1'b1;
        rd = stage_q[LATENCY];
        if (cop.cop_rdywr) begin
          ready   = 1'b1;
          state_d = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 0 loads at capture; each BUSY cycle moves the result one stage toward the output.
  always_comb begin
    stage_d = stage_q;
    if (capture) begin
      stage_d[0] = alu_res;
    end else if (shift) begin
      for (int i = 1; i <= int'(LATENCY); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i <= int'(LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  assign cop.cop_ready = ready;
  assign cop.cop_wait  = busy;
  assign cop.cop_wr    = wr;
  assign cop.cop_rd    = rd;

endmodule

// File: tb/tb_cop_ise_pipe.sv
// Bench for cop_ise_pipe: five instances (LATENCY 0..3 full ISE, LATENCY 0 XORROL-only) behind one core driver.
// Expected results are queued at issue and compared on the cycle write-back is due.
module tb_cop_ise_pipe;
  import cop_ise_pkg::*;

  localparam int ND = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        rdywr;
  logic [31:0] insn;
  logic [31:0] rs1;
  logic [31:0] rs2;
  int          dsel;

  logic [ND-1:0] o_ready;
  logic [ND-1:0] o_wait;
  logic [ND-1:0] o_wr;
  logic [31:0]   o_rd [ND];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    cop_ise_pipe_if ifc ();

    assign ifc.cop_valid = valid && (dsel == g);
    assign ifc.cop_rdywr = rdywr;
    assign ifc.cop_insn  = insn;
    assign ifc.cop_rs1   = rs1;
    assign ifc.cop_rs2   = rs2;
    assign o_ready[g]    = ifc.cop_ready;
    assign o_wait[g]     = ifc.cop_wait;
    assign o_wr[g]       = ifc.cop_wr;
    assign o_rd[g]       = ifc.cop_rd;

    cop_ise_pipe #(
      .ISE_V   ((g == 4) ? 2'b10 : 2'b11),
      .LATENCY ((g == 4) ? 0 : g),
      .ROT_A   (5),
      .ROT_B   (14)
    ) u_dut (
      .cop_clk (clk),
      .cop_rst (rst),
      .cop     (ifc.slave)
    );
  end

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, 3'b000, 5'd3, opc};
  endfunction

  // Independent reference: rotates written as explicit bit slices.
  function automatic logic [31:0] model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    if (i[31:25] == 7'b0100000) return {a[26:0], a[31:27]} ^ {b[17:0], b[31:18]};
    return ~a & b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ready"}, o_ready[dsel], 0);
    chk({tag, "_wr"}, o_wr[dsel], 0);
    chk({tag, "_wait"}, o_wait[dsel], 0);
    chk({tag, "_rd"}, o_rd[dsel], 0);
    @(posedge clk); #1;
  endtask

  task automatic unsup(input logic [31:0] i_insn);
    valid = 1'b1;
    insn  = i_insn;
    rs1   = 32'hFFFF_FFFF;
    rs2   = 32'hFFFF_FFFF;
    rdywr = 1'b1;
    @(negedge clk);
    chk("unsup_ready", o_ready[dsel], 1);
    chk("unsup_wr", o_wr[dsel], 0);
    chk("unsup_wait", o_wait[dsel], 0);
    chk("unsup_rd", o_rd[dsel], 0);
    @(posedge clk); #1;
    idle_chk("unsup_after");
  endtask

  // Issue one op and follow it cycle by cycle; rdywr is held low for `stall` cycles of write-back.
  task automatic do_op(input logic [31:0] i_insn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int stall, input int lat);
    int st;
    bit done;
    bit exp_wr;
    bit exp_rdy;
    st    = stall;
    done  = 1'b0;
    valid = 1'b1;
    insn  = i_insn;
    rs1   = a;
    rs2   = b;
    exp_q.push_back(exp);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      exp_wr = (cyc >= lat + 1);
      rdywr  = exp_wr ? (st == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_rdy = exp_wr && rdywr;
      chk("op_wr", o_wr[dsel], exp_wr);
      chk("op_ready", o_ready[dsel], exp_rdy);
      chk("op_wait", o_wait[dsel], !exp_wr || !rdywr);
      chk("op_rd", o_rd[dsel], exp_wr ? exp_q[0] : 32'h0);
      if (exp_rdy) begin
        void'(exp_q.pop_front());
        done = 1'b1;
      end else if (exp_wr) begin
        st--;
      end
      @(posedge clk); #1;
    end
    chk("op_done", 32'(done), 1);
  endtask

  initial begin
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    rst   = 1'b1;
    valid = 1'b0;
    rdywr = 1'b0;
    insn  = '0;
    rs1   = '0;
    rs2   = '0;
    dsel  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      chk("reset_ready", o_ready[k], 0);
      chk("reset_wr", o_wr[k], 0);
      chk("reset_wait", o_wait[k], 0);
      chk("reset_rd", o_rd[k], 0);
    end
    @(posedge clk); #1;

    // Basic XORROL and a stalled ANDN on LATENCY=1.
    dsel = 1;
    do_op(mk(7'b0100000, 7'b0101011), 32'h0000_0001, 32'h0000_0001, 32'h0000_4020, 0, 1);
    do_op(mk(7'b0100001, 7'b0101011), 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_0000, 3, 1);
    idle_chk("t2_idle");

    // Foreign opcode and unknown CUSTOM_1 funct7 both retire without write-back.
    unsup(mk(7'b0100000, 7'b0110011));
    unsup(mk(7'b0000000, 7'b0101011));

    // XORROL-only build: ANDN is unsupported, XORROL completes with zero extra stages.
    dsel = 4;
    unsup(mk(7'b0100001, 7'b0101011));
    do_op(mk(7'b0100000, 7'b0101011), 32'h8000_0000, 32'h0000_0000, 32'h0000_0010, 0, 0);
    idle_chk("t4_idle");

    // Reset while BUSY on LATENCY=3 drops the in-flight result.
    dsel  = 3;
    valid = 1'b1;
    insn  = mk(7'b0100000, 7'b0101011);
    rs1   = 32'hDEAD_BEEF;
    rs2   = 32'h1234_5678;
    rdywr = 1'b1;
    @(negedge clk);
    chk("t5_accept_wait", o_wait[dsel], 1);
    chk("t5_accept_ready", o_ready[dsel], 0);
    @(posedge clk); #1;
    rst   = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    chk("t5_busy_wait", o_wait[dsel], 1);
    chk("t5_busy_wr", o_wr[dsel], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_post_wr", o_wr[dsel], 0);
      chk("t5_post_rd", o_rd[dsel], 0);
      chk("t5_post_wait", o_wait[dsel], 0);
      chk("t5_post_ready", o_ready[dsel], 0);
      @(posedge clk); #1;
    end
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    do_op(mk(7'b0100000, 7'b0101011), a, b, model(mk(7'b0100000, 7'b0101011), a, b), 1, 3);
    idle_chk("t5_idle");

    // Back-to-back random ops with random write-back stalls, swept over LATENCY.
    for (int l = 0; l < 4; l++) begin
      dsel = l;
      for (int n = 0; n < 8; n++) begin
        f7 = ($urandom_range(0, 1) == 1) ? 7'b0100001 : 7'b0100000;
        a  = $urandom;
        b  = $urandom;
        do_op(mk(f7, 7'b0101011), a, b, model(mk(f7, 7'b0101011), a, b), $urandom_range(0, 3), l);
      end
      idle_chk("t6_idle");
    end

    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
